// File: rtl/sonar_scheduler.sv
// sonar_scheduler: round-robin launcher sharing one ranging engine among several sonars
module sonar_scheduler #(
   parameter int NUM_SONARS     = 4,
   parameter int IDXW           = $clog2(NUM_SONARS),
   parameter int GAP_CYCLES     = 1_000_000,
   parameter int TIMEOUT_CYCLES = 5_000_000
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     enable,
   input  logic [NUM_SONARS*7-1:0]  addr_table,
   output logic                     eng_launch,
   output logic [6:0]               eng_addr,
   input  logic                     eng_done,
   input  logic [15:0]              eng_distance,
   output logic [NUM_SONARS*16-1:0] dist_out,
   output logic [NUM_SONARS-1:0]    valid,
   output logic [NUM_SONARS-1:0]    timeout_flag,
   output logic                     round_done,
   output logic [IDXW-1:0]          cur_idx
);
   localparam logic [1:0] IDLE = 2'd0, LAUNCH = 2'd1, WAIT = 2'd2, GAP = 2'd3;
   logic [1:0]      state;
   logic [31:0]     cnt;
   logic [IDXW-1:0] idx;
   logic [6:0]      addr_q;
   logic            last;
   assign last       = idx == IDXW'(NUM_SONARS - 1);
   assign eng_launch = state == LAUNCH;
   assign cur_idx    = idx;
   // The address is held from launch until the measurement and its gap end, so table edits only affect the next launch
   assign eng_addr   = (state == WAIT || state == GAP) ? addr_q : addr_table[7*idx +: 7];
   // Scheduler FSM, counters and per-sensor result bank
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         cnt          <= '0;
         idx          <= '0;
         addr_q       <= addr_table[6:0];
         dist_out     <= '0;
         valid        <= '0;
         timeout_flag <= '0;
         round_done   <= 1'b0;
      end else begin
         round_done <= 1'b0;
         case (state)
            IDLE: if (enable) state <= LAUNCH;
            LAUNCH: begin
               addr_q <= addr_table[7*idx +: 7];
               cnt    <= '0;
               state  <= WAIT;
            end
            WAIT: begin
               if (eng_done) begin
                  dist_out[16*idx +: 16] <= eng_distance;
                  valid[idx]             <= 1'b1;
                  timeout_flag[idx]      <= 1'b0;
                  cnt                    <= '0;
                  state                  <= GAP;
               end else if (cnt == 32'(TIMEOUT_CYCLES - 1)) begin
                  timeout_flag[idx] <= 1'b1;
                  valid[idx]        <= 1'b0;
                  cnt               <= '0;
                  state             <= GAP;
               end else begin
                  cnt <= cnt + 32'd1;
               end
            end
            GAP: begin
               if (cnt == 32'(GAP_CYCLES - 1)) begin
                  cnt        <= '0;
                  idx        <= last ? '0 : idx + 1'b1;
                  round_done <= last;
                  state      <= enable ? LAUNCH : IDLE;
               end else begin
                  cnt <= cnt + 32'd1;
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_sonar_scheduler.sv
// tb_sonar_scheduler: directed checks of launch order, timeouts, enable handling and reset
module tb_sonar_scheduler;
   localparam int N = 3, GAP = 4, TO = 10;
   logic            clk = 1'b0, reset = 1'b1, enable = 1'b0, eng_done = 1'b0;
   logic [15:0]     eng_distance = '0;
   logic [N*7-1:0]  addr_table = {7'h72, 7'h71, 7'h70};
   logic            eng_launch, round_done;
   logic [6:0]      eng_addr;
   logic [N*16-1:0] dist_out;
   logic [N-1:0]    valid, timeout_flag;
   logic [1:0]      cur_idx;
   int cyc = 0, rd_cnt = 0, n_tests = 0, n_fail = 0, lc = 0, lp = 0, e = 0;

   sonar_scheduler #(.NUM_SONARS(N), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset(reset), .enable(enable), .addr_table(addr_table),
      .eng_launch(eng_launch), .eng_addr(eng_addr), .eng_done(eng_done),
      .eng_distance(eng_distance), .dist_out(dist_out), .valid(valid),
      .timeout_flag(timeout_flag), .round_done(round_done), .cur_idx(cur_idx)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) if (round_done) rd_cnt <= rd_cnt + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: sim time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wait_launch(input string tag, input logic [6:0] a, input logic [1:0] i);
      bit seen = 1'b0;
      for (int k = 0; k < 40 && !seen; k++) begin
         @(negedge clk);
         seen = eng_launch;
      end
      check({tag, " launch"}, 64'(seen), 64'd1);
      check({tag, " addr"}, 64'(eng_addr), 64'(a));
      check({tag, " idx"}, 64'(cur_idx), 64'(i));
      lp = lc;
      lc = cyc;
   endtask

   task automatic pulse_done(input logic [15:0] d);
      eng_done = 1'b1;
      eng_distance = d;
      @(negedge clk);
      eng_done = 1'b0;
   endtask

   task automatic serve(input logic [15:0] d, input int delay);
      repeat (delay) @(negedge clk);
      pulse_done(d);
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, " launch"}, 64'(eng_launch), 64'd0);
      check({tag, " addr"}, 64'(eng_addr), 64'h70);
      check({tag, " dist"}, 64'(dist_out), 64'd0);
      check({tag, " valid"}, 64'(valid), 64'd0);
      check({tag, " tmo"}, 64'(timeout_flag), 64'd0);
      check({tag, " rdone"}, 64'(round_done), 64'd0);
      check({tag, " idx"}, 64'(cur_idx), 64'd0);
   endtask

   initial begin
      // 1: reset values, then a clean round with 3-cycle engine latency
      repeat (2) @(negedge clk);
      check_reset_state("rst");
      reset = 1'b0;
      enable = 1'b1;
      wait_launch("r1s0", 7'h70, 2'd0);
      serve(16'd100, 3);
      wait_launch("r1s1", 7'h71, 2'd1);
      check("r1 spacing01", 64'(lc - lp), 64'd8);
      serve(16'd200, 3);
      wait_launch("r1s2", 7'h72, 2'd2);
      check("r1 spacing12", 64'(lc - lp), 64'd8);
      serve(16'd300, 3);
      check("r1 dist", 64'(dist_out), {16'd0, 16'd300, 16'd200, 16'd100});
      check("r1 valid", 64'(valid), 64'b111);
      wait_launch("r2s0", 7'h70, 2'd0);
      check("r1 spacing20", 64'(lc - lp), 64'd8);
      check("r1 round_done", 64'(round_done), 64'd1);
      // 2: sensor 1 never answers
      serve(16'd110, 3);
      check("r1 round count", 64'(rd_cnt), 64'd1);
      wait_launch("r2s1", 7'h71, 2'd1);
      wait_launch("r2s2", 7'h72, 2'd2);
      check("tmo spacing", 64'(lc - lp), 64'd15);
      check("tmo flag", 64'(timeout_flag), 64'b010);
      check("tmo valid", 64'(valid), 64'b101);
      check("tmo keep dist1", 64'(dist_out[31:16]), 64'd200);
      check("tmo dist0", 64'(dist_out[15:0]), 64'd110);
      serve(16'd320, 3);
      // 3: done coincides with the last WAIT cycle
      wait_launch("r3s0", 7'h70, 2'd0);
      serve(16'd555, 10);
      check("coin dist0", 64'(dist_out[15:0]), 64'd555);
      check("coin valid", 64'(valid), 64'b101);
      check("coin tmo", 64'(timeout_flag), 64'b010);
      wait_launch("r3s1", 7'h71, 2'd1);
      check("coin spacing", 64'(lc - lp), 64'd15);
      serve(16'd250, 3);
      check("r3 tmo clear", 64'(timeout_flag), 64'b000);
      check("r3 valid", 64'(valid), 64'b111);
      wait_launch("r3s2", 7'h72, 2'd2);
      serve(16'd330, 3);
      // 4: drop enable during sensor 0 WAIT
      wait_launch("r4s0", 7'h70, 2'd0);
      @(negedge clk);
      enable = 1'b0;
      serve(16'd123, 2);
      repeat (3) @(negedge clk);
      check("dis gap end-1 idx", 64'(cur_idx), 64'd0);
      @(negedge clk);
      check("dis idle idx", 64'(cur_idx), 64'd1);
      check("dis dist", 64'(dist_out), {16'd0, 16'd330, 16'd250, 16'd123});
      // 5: spurious done in IDLE
      @(negedge clk);
      pulse_done(16'd999);
      repeat (2) @(negedge clk);
      check("idle no launch", 64'(eng_launch), 64'd0);
      check("idle spur dist", 64'(dist_out), {16'd0, 16'd330, 16'd250, 16'd123});
      check("idle spur valid", 64'(valid), 64'b111);
      check("idle spur idx", 64'(cur_idx), 64'd1);
      enable = 1'b1;
      e = cyc;
      wait_launch("re s1", 7'h71, 2'd1);
      check("re latency", 64'(lc - e), 64'd1);
      serve(16'd77, 3);
      @(negedge clk);
      pulse_done(16'd888);
      check("gap spur dist", 64'(dist_out), {16'd0, 16'd330, 16'd77, 16'd123});
      check("gap spur valid", 64'(valid), 64'b111);
      wait_launch("re s2", 7'h72, 2'd2);
      check("gap spur spacing", 64'(lc - lp), 64'd8);
      // 6: reset in the middle of WAIT
      repeat (2) @(negedge clk);
      reset = 1'b1;
      enable = 1'b0;
      @(negedge clk);
      check_reset_state("wrst");
      reset = 1'b0;
      @(negedge clk);
      pulse_done(16'd444);
      repeat (3) @(negedge clk);
      check("post rst dist", 64'(dist_out), 64'd0);
      check("post rst valid", 64'(valid), 64'd0);
      check("post rst launch", 64'(eng_launch), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
